multicycle_control_fsm: RTL

//  Multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_control_fsm_if.sv | 38 +++
 rtl/multicycle_control_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Opcode/ready inputs and datapath/memory control outputs of the multi-cycle control FSM.
// The master side is the FSM; the slave side is the datapath and memory it steers.
interface multicycle_control_fsm_if #(
  parameter int unsigned OpcodeW = 6
);
  logic [OpcodeW-1:0] opcode;
  logic               imem_ready;
  logic               dmem_ready;
  logic               imem_req;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic               reg_read;
  logic               alu_src;
  logic [2:0]         alu_op;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               retire;
  logic               illegal_op;
  logic               bus_err;

  modport master (
    input  opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg_read, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_dst, reg_write, retire,
           illegal_op, bus_err
  );

  modport slave (
    output opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg_read, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_dst, reg_write, retire,
           illegal_op, bus_err
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// stalls on memory handshakes, and traps on illegal opcodes or a stall watchdog timeout.
module multicycle_control_fsm #(
  parameter int unsigned          OpcodeW  = 6,
  parameter logic [OpcodeW-1:0]   OpLw     = 6'b101000,
  parameter logic [OpcodeW-1:0]   OpSw     = 6'b100011,
  parameter logic [OpcodeW-1:0]   OpLsr    = 6'b110010,
  parameter logic [OpcodeW-1:0]   OpRsr    = 6'b111011,
  parameter logic [OpcodeW-1:0]   OpJ      = 6'b000010,
  parameter int unsigned          StallMax = 15
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  multicycle_control_fsm_if.master        bus_io
);

  localparam int unsigned CntW = $clog2(StallMax + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [OpcodeW-1:0] op_q, op_d;
  logic [CntW-1:0]    stall_q, stall_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  function automatic logic [2:0] alu_op_of(input logic [OpcodeW-1:0] op);
    if (op == OpLsr)      return 3'b100;
    else if (op == OpRsr) return 3'b101;
    else if (op == OpJ)   return 3'b111;
    else                  return 3'b000;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= '0;
      stall_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      stall_q   <= stall_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    stall_d   = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;

    bus_io.imem_req   = 1'b0;
    bus_io.ir_write   = 1'b0;
    bus_io.pc_write   = 1'b0;
    bus_io.pc_src     = 1'b0;
    bus_io.reg_read   = 1'b0;
    bus_io.alu_src    = 1'b0;
    bus_io.alu_op     = 3'b000;
    bus_io.mem_read   = 1'b0;
    bus_io.mem_write  = 1'b0;
    bus_io.mem_to_reg = 1'b0;
    bus_io.reg_dst    = 1'b0;
    bus_io.reg_write  = 1'b0;
    bus_io.retire     = 1'b0;
    bus_io.illegal_op = illegal_q;
    bus_io.bus_err    = bus_err_q;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        bus_io.imem_req = 1'b1;
        if (bus_io.imem_ready) begin
          bus_io.ir_write = 1'b1;
          bus_io.pc_write = 1'b1;
          state_d         = StDecode;
        end else if (stall_q == CntW'(StallMax)) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          stall_d = stall_q + CntW'(1);
        end
      end

      // The live opcode is used here since op_q only captures it at the end of this cycle.
      StDecode: begin
        bus_io.reg_read = 1'b1;
        op_d            = bus_io.opcode;
        if (bus_io.opcode == OpJ) begin
          bus_io.pc_write = 1'b1;
          bus_io.pc_src   = 1'b1;
          bus_io.retire   = 1'b1;
          state_d         = StFetch;
        end else if (bus_io.opcode == OpLw || bus_io.opcode == OpSw ||
                     bus_io.opcode == OpLsr || bus_io.opcode == OpRsr) begin
          state_d = StExec;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end

      StExec: begin
        bus_io.alu_op  = alu_op_of(op_q);
        bus_io.alu_src = (op_q == OpLw) || (op_q == OpSw);
        state_d        = bus_io.alu_src ? StMem : StWb;
      end

      StMem: begin
        bus_io.mem_read  = (op_q == OpLw);
        bus_io.mem_write = (op_q == OpSw);
        if (bus_io.dmem_ready) begin
          if (op_q == OpLw) begin
            state_d = StWb;
          end else begin
            bus_io.retire = 1'b1;
            state_d       = StFetch;
          end
        end else if (stall_q == CntW'(StallMax)) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          stall_d = stall_q + CntW'(1);
        end
      end

      StWb: begin
        bus_io.reg_write  = 1'b1;
        bus_io.mem_to_reg = (op_q == OpLw);
        bus_io.reg_dst    = (op_q != OpLw);
        bus_io.retire     = 1'b1;
        state_d           = StFetch;
      end

      StTrap: state_d = StTrap;

      default: state_d = StIdle;
    endcase
  end

endmodule
